// File: rtl/aes_pkg.sv
// Shared AES constants, key-stream FSM encoding and byte-level helpers.
//   Nk, Nr, Nb : AES-128 geometry (key words, rounds, state words)
//   state_e    : inv_key_stream controller states
//   sbox()     : forward S-box lookup
//   rcon_fwd() : xtime, advances rcon one round forward
//   rcon_inv() : undoes rcon_fwd over the AES-128 rcon sequence
//   rot_word() : cyclic left byte rotation of a 32-bit word
package aes_pkg;

  localparam int unsigned Nk = 4;
  localparam int unsigned Nr = 10;
  localparam int unsigned Nb = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StEmit
  } state_e;

  // Element 0 sits in the most significant byte, so SBOX[b] is S(b).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon_fwd(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the two reduction points of the rcon sequence need special cases.
  function automatic logic [7:0] rcon_inv(input logic [7:0] r);
    logic [7:0] res;
    case (r)
      8'h36:   res = 8'h1b;
      8'h1b:   res = 8'h80;
      default: res = r >> 1;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/inv_key_stream_sbytes.sv
// Combinational SubBytes over NWords 32-bit words.
//   i_data : input words
//   o_data : S-box substituted words, same byte positions
module inv_key_stream_sbytes
  import aes_pkg::*;
#(
  parameter int unsigned NWords = 1
) (
  input  logic [32*NWords-1:0] i_data,
  output logic [32*NWords-1:0] o_data
);

  for (genvar gi = 0; gi < 4 * NWords; gi++) begin : g_byte
    assign o_data[8*gi +: 8] = sbox(i_data[8*gi +: 8]);
  end

endmodule

// File: rtl/inv_key_stream.sv
// AES-128 inverse key stream: expands a cipher key forward to round key 10,
// then emits round keys 10 down to 0 over a valid/ready stream, stepping the
// schedule backwards on each accepted key.
//   clk, rst            : clock, synchronous active-high reset
//   key_in/valid/ready  : cipher key intake (accepted only when idle)
//   rk_out/round/last   : current round key, its index, index==0 flag
//   rk_valid/rk_ready   : round key handshake
//   busy                : controller not idle
module inv_key_stream
  import aes_pkg::*;
#(
  parameter int unsigned Nk = aes_pkg::Nk,
  parameter int unsigned Nr = aes_pkg::Nr,
  parameter int unsigned Nb = aes_pkg::Nb
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [32*Nk-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [32*Nb-1:0] rk_out,
  output logic [3:0]       rk_round,
  output logic             rk_last,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy
);

  state_e       r_state, w_state_d;
  logic [127:0] r_key, w_key_d;
  logic [3:0]   r_round, w_round_d;
  logic [7:0]   r_rcon, w_rcon_d;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_w3p;
  logic [31:0]  w_sub_in, w_sub_out, w_rcon_word;
  logic [127:0] w_key_fwd, w_key_inv;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_w3p       = w_w3 ^ w_w2;
  assign w_rcon_word = {r_rcon, 24'h0};

  // The single S-box word serves both directions: backwards, the previous
  // round's w3 must be rebuilt before it can be substituted.
  assign w_sub_in = (r_state == StEmit) ? rot_word(w_w3p) : rot_word(w_w3);

  inv_key_stream_sbytes #(
    .NWords(1)
  ) u_sbytes (
    .i_data(w_sub_in),
    .o_data(w_sub_out)
  );

  assign w_f0      = w_w0 ^ w_sub_out ^ w_rcon_word;
  assign w_f1      = w_w1 ^ w_f0;
  assign w_f2      = w_w2 ^ w_f1;
  assign w_f3      = w_w3 ^ w_f2;
  assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};

  assign w_key_inv = {w_w0 ^ w_sub_out ^ w_rcon_word, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3p};

  always_comb begin
    w_state_d = r_state;
    w_key_d   = r_key;
    w_round_d = r_round;
    w_rcon_d  = r_rcon;
    unique case (r_state)
      StIdle: begin
        if (key_valid) begin
          w_key_d   = key_in;
          w_rcon_d  = 8'h01;
          w_round_d = 4'd0;
          w_state_d = StFwd;
        end
      end
      StFwd: begin
        w_key_d   = w_key_fwd;
        w_round_d = r_round + 4'd1;
        // rcon stays at the final-round value so the first inverse step uses it.
        if (r_round == 4'(Nr - 1)) begin
          w_state_d = StEmit;
        end else begin
          w_rcon_d = rcon_fwd(r_rcon);
        end
      end
      StEmit: begin
        if (rk_ready) begin
          if (r_round == 4'd0) begin
            w_state_d = StIdle;
          end else begin
            w_key_d   = w_key_inv;
            w_round_d = r_round - 4'd1;
            w_rcon_d  = rcon_inv(r_rcon);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_key   <= '0;
      r_round <= 4'd0;
      r_rcon  <= 8'h01;
    end else begin
      r_state <= w_state_d;
      r_key   <= w_key_d;
      r_round <= w_round_d;
      r_rcon  <= w_rcon_d;
    end
  end

  assign key_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign rk_valid  = (r_state == StEmit);
  assign rk_out    = r_key;
  assign rk_round  = r_round;
  assign rk_last   = (r_state == StEmit) && (r_round == 4'd0);

endmodule

// File: tb/tb_inv_key_stream.sv
// Directed bench for inv_key_stream: reset behaviour, FIPS-197 known answer,
// latency, zero-bubble streaming, backpressure stability, mid-run resets and
// all-zero / all-ones keys against an independent forward key expansion.
module tb_inv_key_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [0:255][7:0] sb;
  logic [7:0]        rc_tab [0:9];
  logic [127:0]      exp_rk [0:10];
  logic [135:0]      idle_exp;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  inv_key_stream dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_last  (rk_last),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy)
  );

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
  endfunction

  // Textbook forward expansion; fills exp_rk[0..10].
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rc_tab[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic stream_key(input logic [127:0] key, input bit random_bp, input bit hold_valid);
    int cnt;
    int r;
    int cycles;
    bit rdy;
    @(negedge clk);
    n_vec++;
    if (key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL key_ready_idle: got %b want 1", key_ready);
    end
    key_in    = key;
    key_valid = 1'b1;
    rk_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) key_valid = 1'b0;
    cnt = 0;
    while (rk_valid !== 1'b1 && cnt < 20) begin
      n_vec++;
      if (key_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL fwd_flags: got key_ready=%b busy=%b want 0 1", key_ready, busy);
      end
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt != 10) begin
      n_err++;
      $display("FAIL latency: got %0d edges want 10", cnt);
    end
    r = 10;
    cycles = 0;
    while (r >= 0 && cycles < 200) begin
      n_vec++;
      if ({rk_valid, rk_last, key_ready, busy, rk_round, rk_out} !==
          {1'b1, (r == 0), 1'b0, 1'b1, 4'(r), exp_rk[r]}) begin
        n_err++;
        $display("FAIL emit_round%0d: got valid=%b last=%b kready=%b busy=%b round=%0d rk=%h want rk=%h",
                 r, rk_valid, rk_last, key_ready, busy, rk_round, rk_out, exp_rk[r]);
      end
      rdy = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (rdy) r--;
    end
    n_vec++;
    if (r >= 0) begin
      n_err++;
      $display("FAIL emit_timeout: got round %0d left want all sent", r);
    end
    if (!random_bp) begin
      n_vec++;
      if (cycles != 11) begin
        n_err++;
        $display("FAIL zero_bubble: got %0d cycles want 11", cycles);
      end
    end
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    n_vec++;
    if ({rk_valid, key_ready, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL post_handshake: got valid=%b kready=%b busy=%b want 0 1 0",
               rk_valid, key_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    key_valid = 1'b1;
    key_in    = FipsKey;
    rk_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({key_ready, rk_valid, rk_last, busy, rk_round, rk_out} !== idle_exp) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h",
               {key_ready, rk_valid, rk_last, busy, rk_round, rk_out}, idle_exp);
    end
    rst       = 1'b0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({key_ready, rk_valid, rk_last, busy, rk_round, rk_out} !== idle_exp) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h",
               {key_ready, rk_valid, rk_last, busy, rk_round, rk_out}, idle_exp);
    end
  endtask

  task automatic test_fips();
    compute_model(FipsKey);
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[0]  = FipsKey;
    stream_key(FipsKey, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    compute_model(FipsKey);
    stream_key(FipsKey, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_fwd();
    bit seen;
    @(negedge clk);
    key_in    = FipsKey;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || rk_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_fwd_state: got busy=%b valid=%b want 1 0", busy, rk_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({key_ready, rk_valid, rk_last, busy, rk_round, rk_out} !== idle_exp) begin
      n_err++;
      $display("FAIL reset_mid_fwd: got %h want %h",
               {key_ready, rk_valid, rk_last, busy, rk_round, rk_out}, idle_exp);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rk_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL abort_fwd: got activity after reset want none");
    end
  endtask

  task automatic test_reset_mid_emit();
    int cnt;
    @(negedge clk);
    key_in    = FipsKey;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    cnt = 0;
    while ((rk_valid !== 1'b1 || rk_round !== 4'd7) && cnt < 40) begin
      rk_ready = rk_valid;
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd7) begin
      n_err++;
      $display("FAIL reach_round7: got valid=%b round=%0d want 1 7", rk_valid, rk_round);
    end
    rst       = 1'b1;
    rk_ready  = 1'b1;
    key_valid = 1'b1;
    key_in    = '1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    rk_ready  = 1'b0;
    key_valid = 1'b0;
    n_vec++;
    if ({key_ready, rk_valid, rk_last, busy, rk_round, rk_out} !== idle_exp) begin
      n_err++;
      $display("FAIL reset_mid_emit: got %h want %h",
               {key_ready, rk_valid, rk_last, busy, rk_round, rk_out}, idle_exp);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_emit: got valid=%b busy=%b want 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_zero_ones();
    compute_model('0);
    stream_key('0, 1'b0, 1'b1);
    compute_model('1);
    stream_key('1, 1'b1, 1'b1);
  endtask

  initial begin
    sb = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    rc_tab[0] = 8'h01; rc_tab[1] = 8'h02; rc_tab[2] = 8'h04; rc_tab[3] = 8'h08;
    rc_tab[4] = 8'h10; rc_tab[5] = 8'h20; rc_tab[6] = 8'h40; rc_tab[7] = 8'h80;
    rc_tab[8] = 8'h1b; rc_tab[9] = 8'h36;
    // key_ready=1, everything else zero.
    idle_exp  = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 128'd0};
    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;

    test_reset();
    test_fips();
    test_backpressure();
    test_reset_mid_fwd();
    test_reset_mid_emit();
    test_fips();
    test_zero_ones();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
